vga_text_renderer: RTL and testbench
====================================

Name: vga_text_renderer

Overview:
- Drives a 640x480 VGA display and renders an 8-character text line using the 3-bit-code, 16-row x 8-pixel glyph ROM (Almacenamiento) that sits directly downstream.
- Generates sync timing, computes glyph code and row address for the ROM, consumes its 8-bit row data and serialises it into RGB332 pixels.
- Sits between the board pixel-clock enable and the VGA connector. The message comes from control logic upstream.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths
- TEXT_X0, 256, left edge of text window; must be a multiple of 8
- TEXT_Y0, 224, top edge of text window; must be a multiple of 16
- FG_COLOR, 8'hFF, RGB332 colour of set glyph bits
- BG_COLOR, 8'h00, RGB332 colour of clear bits inside the active area

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- pix_en  in  1  one-clk pixel tick (25 MHz rate); all state advances only when high
- msg  in  24  8 glyph codes; slot k = msg[3k+2:3k], slot 0 leftmost
- direccion  out  3  glyph code to ROM
- rom  out  4  glyph row to ROM
- rom_data  in  8  ROM row bits; bit 7 = leftmost pixel; combinational return
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high while the output pixel is in the active area
- rgb  out  8  RGB332 pixel
- frame_start  out  1  one-clk pulse when counters wrap to (0,0)

Behaviour:
- Reset (async, rst_n=0): h_cnt=0, v_cnt=0, msg_q=0, direccion=0, rom=0, hsync=1, vsync=1, video_on=0, rgb=0, frame_start=0. Reset asserted mid-line aborts the frame immediately; on release, counting restarts at (0,0) on the first pix_en.
- pix_en=0: every register holds; frame_start is 0.
- Counters:
  - h_cnt runs 0..799 and wraps to 0.
  - v_cnt increments on each h wrap and runs 0..524, wrapping to 0.
  - frame_start=1 for the clk on which both counters wrap together.
- msg_q latches msg only on that wrap cycle, so a message change never tears within a frame.
- Stage 1 (registered on pix_en), from the current counters:
  - In window (TEXT_X0 <= h < TEXT_X0+64 and TEXT_Y0 <= v < TEXT_Y0+16): slot = (h-TEXT_X0)>>3, direccion = msg_q[slot], rom = (v-TEXT_Y0)[3:0], col = (h-TEXT_X0)[2:0].
  - Outside the window: direccion=0 and rom=0 (space glyph), in_win=0.
  - Sync, active and in_win flags are registered alongside.
- Stage 2 (registered on pix_en):
  - Not active: rgb=0.
  - Active and not in_win: rgb=BG_COLOR.
  - Active and in_win: rgb = rom_data[7-col] ? FG_COLOR : BG_COLOR.
  - hsync, vsync and video_on are registered in the same stage.
- Latency: every output is exactly 2 pix_en ticks behind the counter state it describes, so sync and pixel stay aligned.
- Sync timing (counter domain): hsync low for 656 <= h <= 751; vsync low for 490 <= v <= 491. Active area is h < 640 and v < 480.
- Code 0 renders as blank. Codes 7 and unused ROM rows return 0 from the ROM and render as background.
- Widths: h_cnt and v_cnt are 10 bits. Window subtraction is done in 10 bits; the result is used only when in window.

Decomposition:
- Package vga_text_pkg: timing constants (H_TOTAL=800, V_TOTAL=525, sync start/end), RGB332 colour constants, GLYPH_W=8, GLYPH_H=16, MSG_SLOTS=8.
- Sub-module vga_timing: the counters, the sync/active decode and frame_start.
- The top level holds msg_q, the two pipeline stages and the ROM address mux.

Test Plan:
- Reset release, then 800 pix_en ticks -> hsync low for exactly 96 ticks, first falling at tick 658 (656+2 latency); vsync stays high on line 0.
- Full frame of 420000 ticks -> vsync low for exactly 2 lines (1600 ticks); frame_start pulses once, at tick 419999.
- msg=24'h000001 (slot0=J), line v=TEXT_Y0+2 -> direccion=1, rom=2 during h=256..263. Two ticks later rgb = FF×7 then 00 (pattern 11111110); h=264..319 gives rgb=00 (slot code 0).
- Window edges on line TEXT_Y0+5 -> h=255 and h=320 produce direccion=0 and rgb=BG_COLOR; h=640 onward gives rgb=0 and video_on=0.
- msg changed mid-frame from J to V -> the current frame still shows J; V appears from the next frame_start. Check with V row 9 = 01101100.
- pix_en held low for 10 clks mid-line, then rst_n pulsed low for 1 clk -> outputs frozen during the hold; the reset drives all outputs to their reset values asynchronously and counting resumes at (0,0).

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared timing defaults, colours and glyph geometry for the VGA text renderer.
package vga_text_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
    localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

    localparam logic [7:0] COLOR_WHITE = 8'hFF;
    localparam logic [7:0] COLOR_BLACK = 8'h00;

    localparam int GLYPH_W   = 8;
    localparam int GLYPH_H   = 16;
    localparam int MSG_SLOTS = 8;
    localparam int TEXT_W    = GLYPH_W * MSG_SLOTS;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
    } sync_t;

    // Slot k occupies bits [3k+2:3k]; slot 0 is the leftmost character.
    function automatic logic [2:0] slotCode(input logic [3*MSG_SLOTS-1:0] msg,
                                            input logic [2:0] slot);
        logic [4:0] base;
        base = 5'(slot) * 5'd3;
        return msg[base +: 3];
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical pixel counters with sync, active-area and frame-start decode.
module vga_timing
    import vga_text_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pix_en,
    output logic [9:0] o_hCnt,
    output logic [9:0] o_vCnt,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_active,
    output logic       o_frame_start
);

    localparam int H_LAST    = H_ACTIVE + H_FP + H_SYNC + H_BP - 1;
    localparam int V_LAST    = V_ACTIVE + V_FP + V_SYNC + V_BP - 1;
    localparam int H_SYNC_LO = H_ACTIVE + H_FP;
    localparam int H_SYNC_HI = H_SYNC_LO + H_SYNC - 1;
    localparam int V_SYNC_LO = V_ACTIVE + V_FP;
    localparam int V_SYNC_HI = V_SYNC_LO + V_SYNC - 1;

    logic [9:0] r_hCnt;
    logic [9:0] r_vCnt;
    logic       w_hWrap;
    logic       w_vWrap;

    assign w_hWrap = (r_hCnt == 10'(H_LAST));
    assign w_vWrap = (r_vCnt == 10'(V_LAST));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hCnt <= '0;
            r_vCnt <= '0;
        end else if (i_pix_en) begin
            if (w_hWrap) begin
                r_hCnt <= '0;
                r_vCnt <= w_vWrap ? 10'd0 : r_vCnt + 10'd1;
            end else begin
                r_hCnt <= r_hCnt + 10'd1;
            end
        end
    end

    assign o_hCnt        = r_hCnt;
    assign o_vCnt        = r_vCnt;
    assign o_hsync       = !((r_hCnt >= 10'(H_SYNC_LO)) && (r_hCnt <= 10'(H_SYNC_HI)));
    assign o_vsync       = !((r_vCnt >= 10'(V_SYNC_LO)) && (r_vCnt <= 10'(V_SYNC_HI)));
    assign o_active      = (r_hCnt < 10'(H_ACTIVE)) && (r_vCnt < 10'(V_ACTIVE));
    assign o_frame_start = i_pix_en && w_hWrap && w_vWrap;

endmodule

// File: rtl/vga_text_renderer.sv
// 8-character text line on a 640x480 VGA raster: glyph ROM addressing plus a
// two-stage pixel pipeline that keeps RGB aligned with the delayed sync outputs.
module vga_text_renderer
    import vga_text_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int TEXT_X0  = 256,
    parameter int TEXT_Y0  = 224,
    parameter logic [7:0] FG_COLOR = COLOR_WHITE,
    parameter logic [7:0] BG_COLOR = COLOR_BLACK
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pix_en,
    input  logic [23:0] i_msg,
    output logic [2:0]  o_direccion,
    output logic [3:0]  o_rom,
    input  logic [7:0]  i_rom_data,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_video_on,
    output logic [7:0]  o_rgb,
    output logic        o_frame_start
);

    logic [9:0] w_hCnt;
    logic [9:0] w_vCnt;
    logic       w_hsync;
    logic       w_vsync;
    logic       w_active;
    logic       w_frameStart;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_pix_en      (i_pix_en),
        .o_hCnt        (w_hCnt),
        .o_vCnt        (w_vCnt),
        .o_hsync       (w_hsync),
        .o_vsync       (w_vsync),
        .o_active      (w_active),
        .o_frame_start (w_frameStart)
    );

    // The message is only sampled at the frame wrap so a frame never shows two messages.
    logic [23:0] r_msgQ;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_msgQ <= '0;
        end else if (w_frameStart) begin
            r_msgQ <= i_msg;
        end
    end

    // Offsets are garbage outside the window; they are only consumed when w_inWin is set.
    logic [5:0] w_hOff;
    logic [3:0] w_vOff;
    logic       w_inWin;
    logic [2:0] w_dirNext;
    logic [3:0] w_romNext;

    assign w_hOff  = 6'(w_hCnt - 10'(TEXT_X0));
    assign w_vOff  = 4'(w_vCnt - 10'(TEXT_Y0));
    assign w_inWin = (w_hCnt >= 10'(TEXT_X0)) && (w_hCnt < 10'(TEXT_X0 + TEXT_W)) &&
                     (w_vCnt >= 10'(TEXT_Y0)) && (w_vCnt < 10'(TEXT_Y0 + GLYPH_H));

    always_comb begin
        w_dirNext = 3'd0;
        w_romNext = 4'd0;
        if (w_inWin) begin
            w_dirNext = slotCode(r_msgQ, w_hOff[5:3]);
            w_romNext = w_vOff;
        end
    end

    logic [2:0] r_dir;
    logic [3:0] r_rom;
    logic [2:0] r_col;
    logic       r_inWin;
    sync_t      r_syncS1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dir    <= '0;
            r_rom    <= '0;
            r_col    <= '0;
            r_inWin  <= 1'b0;
            r_syncS1 <= '{hsync: 1'b1, vsync: 1'b1, active: 1'b0};
        end else if (i_pix_en) begin
            r_dir    <= w_dirNext;
            r_rom    <= w_romNext;
            r_col    <= w_inWin ? w_hOff[2:0] : 3'd0;
            r_inWin  <= w_inWin;
            r_syncS1 <= '{hsync: w_hsync, vsync: w_vsync, active: w_active};
        end
    end

    // The ROM answers combinationally, so its row data lines up with stage-1 state.
    logic       w_pixBit;
    logic [7:0] w_rgbNext;

    assign w_pixBit = i_rom_data[3'd7 - r_col];

    always_comb begin
        w_rgbNext = 8'h00;
        if (r_syncS1.active) begin
            w_rgbNext = (r_inWin && w_pixBit) ? FG_COLOR : BG_COLOR;
        end
    end

    logic [7:0] r_rgb;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_videoOn;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rgb     <= '0;
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_videoOn <= 1'b0;
        end else if (i_pix_en) begin
            r_rgb     <= w_rgbNext;
            r_hsync   <= r_syncS1.hsync;
            r_vsync   <= r_syncS1.vsync;
            r_videoOn <= r_syncS1.active;
        end
    end

    assign o_direccion   = r_dir;
    assign o_rom         = r_rom;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_video_on    = r_videoOn;
    assign o_rgb         = r_rgb;
    assign o_frame_start = w_frameStart;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Scoreboard bench for vga_text_renderer with a behavioural glyph ROM on the address outputs.
module tb_vga_text_renderer;

    localparam int H_TOTAL_TB  = 800;
    localparam int V_ACTIVE_TB = 26;
    localparam int V_FP_TB     = 1;
    localparam int V_SYNC_TB   = 2;
    localparam int V_BP_TB     = 1;
    localparam int V_TOTAL_TB  = V_ACTIVE_TB + V_FP_TB + V_SYNC_TB + V_BP_TB;
    localparam int FRAME_TICKS = H_TOTAL_TB * V_TOTAL_TB;
    localparam int X0          = 256;
    localparam int Y0          = 16;

    typedef struct {
        int         h;
        int         v;
        int         f;
        logic       hs;
        logic       vs;
        logic       vid;
        logic [7:0] rgb;
    } expEntry_t;

    logic        clock = 1'b0;
    logic        resetN;
    logic        pixEn;
    logic [23:0] msg;
    logic [2:0]  direccion;
    logic [3:0]  rom;
    logic [7:0]  romData;
    logic        hsync;
    logic        vsync;
    logic        videoOn;
    logic [7:0]  rgb;
    logic        frameStart;

    int checks = 0;
    int errors = 0;
    int tagH = -1;
    int tagV = -1;

    int          mh, mv, frameIdx, edgeCount;
    logic [23:0] msgQ;
    expEntry_t   sb[$];
    expEntry_t   lastExp;
    logic [2:0]  lastDir;
    logic [3:0]  lastRom;
    int          hLow, firstFall, vLowLine0, vLow, fsCount, fsState, nonBlank;
    logic [7:0]  jRow2, jRow9, vRow9;

    always #5 clock = ~clock;

    vga_text_renderer #(
        .V_ACTIVE (V_ACTIVE_TB),
        .V_FP     (V_FP_TB),
        .V_SYNC   (V_SYNC_TB),
        .V_BP     (V_BP_TB),
        .TEXT_X0  (X0),
        .TEXT_Y0  (Y0)
    ) dut (
        .i_clk         (clock),
        .i_rst_n       (resetN),
        .i_pix_en      (pixEn),
        .i_msg         (msg),
        .o_direccion   (direccion),
        .o_rom         (rom),
        .i_rom_data    (romData),
        .o_hsync       (hsync),
        .o_vsync       (vsync),
        .o_video_on    (videoOn),
        .o_rgb         (rgb),
        .o_frame_start (frameStart)
    );

    // Behavioural glyph ROM: code 1 = J, code 2 = V, codes 0/7 and rows 12..15 read as zero.
    function automatic logic [7:0] romModel(input logic [2:0] code, input logic [3:0] row);
        logic [7:0] bits;
        bits = 8'h00;
        if (row < 4'd12) begin
            case (code)
                3'd1:                bits = (row == 4'd2) ? 8'hFE : 8'h0C;
                3'd2:                bits = (row == 4'd9) ? 8'h6C : 8'hC6;
                3'd3, 3'd4, 3'd5, 3'd6: bits = {code, row, 1'b1};
                default:             bits = 8'h00;
            endcase
        end
        return bits;
    endfunction

    assign romData = romModel(direccion, rom);

    function automatic logic inWindow(input int h, input int v);
        return (h >= X0) && (h < X0 + 64) && (v >= Y0) && (v < Y0 + 16);
    endfunction

    function automatic logic [2:0] codeAt(input int h, input logic [23:0] m);
        return 3'(m >> (3 * ((h - X0) / 8)));
    endfunction

    function automatic expEntry_t expectFor(input int h, input int v, input logic [23:0] m,
                                            input int f);
        expEntry_t  e;
        logic [7:0] bits;
        e.h   = h;
        e.v   = v;
        e.f   = f;
        e.hs  = !((h >= 656) && (h <= 751));
        e.vs  = !((v >= V_ACTIVE_TB + V_FP_TB) && (v < V_ACTIVE_TB + V_FP_TB + V_SYNC_TB));
        e.vid = (h < 640) && (v < V_ACTIVE_TB);
        e.rgb = 8'h00;
        if (e.vid && inWindow(h, v)) begin
            bits = romModel(codeAt(h, m), 4'(v - Y0));
            if (bits[7 - ((h - X0) % 8)]) e.rgb = 8'hFF;
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            if (errors <= 40)
                $display("[TB] FAIL %s at h=%0d v=%0d: observed %0h, expected %0h",
                         tag, tagH, tagV, observed, expected);
        end
    endtask

    task automatic compareEntry(input expEntry_t e);
        tagH = e.h;
        tagV = e.v;
        checkOutput("hsync", 32'(hsync), 32'(e.hs));
        checkOutput("vsync", 32'(vsync), 32'(e.vs));
        checkOutput("video_on", 32'(videoOn), 32'(e.vid));
        checkOutput("rgb", 32'(rgb), 32'(e.rgb));
    endtask

    task automatic resetModel();
        expEntry_t r;
        r.h = -1; r.v = -1; r.f = -1;
        r.hs = 1'b1; r.vs = 1'b1; r.vid = 1'b0; r.rgb = 8'h00;
        sb.delete();
        sb.push_back(r);
        lastExp   = r;
        lastDir   = 3'd0;
        lastRom   = 4'd0;
        mh        = 0;
        mv        = 0;
        msgQ      = 24'h0;
        frameIdx  = 0;
        edgeCount = 0;
        hLow      = 0;
        firstFall = 0;
        vLowLine0 = 0;
        vLow      = 0;
        fsCount   = 0;
        fsState   = -1;
    endtask

    task automatic trackEntry(input expEntry_t e);
        edgeCount++;
        if (edgeCount <= H_TOTAL_TB) begin
            if (!hsync) begin
                hLow++;
                if (firstFall == 0) firstFall = edgeCount;
            end
            if (!vsync) vLowLine0++;
        end
        if (edgeCount <= FRAME_TICKS && !vsync) vLow++;
        if (e.h >= X0 && e.h < X0 + 8) begin
            if (e.f == 1 && e.v == Y0 + 2) jRow2 = {jRow2[6:0], rgb == 8'hFF};
            if (e.f == 1 && e.v == Y0 + 9) jRow9 = {jRow9[6:0], rgb == 8'hFF};
            if (e.f == 2 && e.v == Y0 + 9) vRow9 = {vRow9[6:0], rgb == 8'hFF};
        end
        if (e.f == 1 && e.v == Y0 + 2 && e.h >= X0 + 8 && e.h < X0 + 64 && rgb != 8'h00)
            nonBlank++;
    endtask

    task automatic applyStimulus(input logic en);
        expEntry_t  cur;
        logic [2:0] expDir;
        logic [3:0] expRom;
        @(negedge clock);
        pixEn = en;
        #1;
        tagH = mh;
        tagV = mv;
        checkOutput("frame_start", 32'(frameStart),
                    32'(en && (mh == H_TOTAL_TB - 1) && (mv == V_TOTAL_TB - 1)));
        if (frameStart) begin
            fsCount++;
            fsState = mv * H_TOTAL_TB + mh;
        end
        @(posedge clock);
        #1;
        if (en) begin
            expDir = inWindow(mh, mv) ? codeAt(mh, msgQ) : 3'd0;
            expRom = inWindow(mh, mv) ? 4'(mv - Y0) : 4'd0;
            tagH = mh;
            tagV = mv;
            checkOutput("direccion", 32'(direccion), 32'(expDir));
            checkOutput("rom", 32'(rom), 32'(expRom));
            lastDir = expDir;
            lastRom = expRom;
            sb.push_back(expectFor(mh, mv, msgQ, frameIdx));
            if (sb.size() < 2) begin
                checkOutput("scoreboard_depth", 32'(sb.size()), 32'd2);
            end else begin
                cur = sb.pop_front();
                compareEntry(cur);
                lastExp = cur;
                trackEntry(cur);
            end
            if (mh == H_TOTAL_TB - 1) begin
                mh = 0;
                if (mv == V_TOTAL_TB - 1) begin
                    mv = 0;
                    msgQ = msg;
                    frameIdx++;
                end else begin
                    mv++;
                end
            end else begin
                mh++;
            end
        end else begin
            checkOutput("hold_direccion", 32'(direccion), 32'(lastDir));
            checkOutput("hold_rom", 32'(rom), 32'(lastRom));
            compareEntry(lastExp);
        end
    endtask

    initial begin
        resetN   = 1'b0;
        pixEn    = 1'b0;
        msg      = 24'h000001;
        jRow2    = 8'h00;
        jRow9    = 8'h00;
        vRow9    = 8'h00;
        nonBlank = 0;
        resetModel();

        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_direccion", 32'(direccion), 32'd0);
        checkOutput("reset_rom", 32'(rom), 32'd0);
        checkOutput("reset_frame_start", 32'(frameStart), 32'd0);
        compareEntry(lastExp);
        @(negedge clock);
        resetN = 1'b1;

        repeat (FRAME_TICKS) applyStimulus(1'b1);
        checkOutput("hsync_low_ticks", 32'(hLow), 32'd96);
        checkOutput("hsync_first_fall", 32'(firstFall), 32'd658);
        checkOutput("vsync_line0_low", 32'(vLowLine0), 32'd0);
        checkOutput("vsync_low_ticks", 32'(vLow), 32'(V_SYNC_TB * H_TOTAL_TB));
        checkOutput("frame_start_count", 32'(fsCount), 32'd1);
        checkOutput("frame_start_tick", 32'(fsState), 32'(FRAME_TICKS - 1));

        repeat ((Y0 + 6) * H_TOTAL_TB) applyStimulus(1'b1);
        msg = 24'hE00002;
        repeat (FRAME_TICKS - (Y0 + 6) * H_TOTAL_TB) applyStimulus(1'b1);
        checkOutput("j_row2_pattern", 32'(jRow2), 32'hFE);
        checkOutput("j_blank_slots", 32'(nonBlank), 32'd0);
        checkOutput("j_row9_kept", 32'(jRow9), 32'h0C);

        repeat ((Y0 + 10) * H_TOTAL_TB + 300) applyStimulus(1'b1);
        checkOutput("v_row9_pattern", 32'(vRow9), 32'h6C);

        repeat (10) applyStimulus(1'b0);

        @(negedge clock);
        #2;
        resetN = 1'b0;
        #1;
        tagH = -1;
        tagV = -1;
        checkOutput("async_rst_hsync", 32'(hsync), 32'd1);
        checkOutput("async_rst_vsync", 32'(vsync), 32'd1);
        checkOutput("async_rst_video_on", 32'(videoOn), 32'd0);
        checkOutput("async_rst_rgb", 32'(rgb), 32'd0);
        checkOutput("async_rst_direccion", 32'(direccion), 32'd0);
        checkOutput("async_rst_rom", 32'(rom), 32'd0);
        checkOutput("async_rst_frame_start", 32'(frameStart), 32'd0);
        @(negedge clock);
        #2;
        resetN = 1'b1;
        resetModel();

        repeat (H_TOTAL_TB + 100) applyStimulus(1'b1);
        checkOutput("restart_hsync_low_ticks", 32'(hLow), 32'd96);
        checkOutput("restart_hsync_first_fall", 32'(firstFall), 32'd658);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
